bcd_countdown_timer: RTL and testbench
======================================

// Module: bcd_countdown_timer
// PURPOSE
//  Presettable multi-digit BCD down-counter with run/pause control, a tick prescaler and a done pulse.
//  Mirror of the up-counting 161 chain: counts down through a borrow chain (192-style), not up through a carry chain.
//  Drives the game countdown; feeds the 7-seg display path directly with Q.
// PARAMETERS
//  DIGITS    4   number of BCD digits (Q width = 4*DIGITS)
//  TICK_DIV  1   CP cycles per decrement while running (1 = every cycle); must be >= 1
// PORTS
//  CP     in   1          clock, rising edge
//  CR     in   1          async clear, active-low
//  load   in   1          sync preset from P, active-high
//  P      in   4*DIGITS   preset value, BCD, digit 0 in P[3:0]
//  start  in   1          begin/resume counting (level sampled each CP)
//  pause  in   1          suspend counting (level sampled each CP)
//  Q      out  4*DIGITS   current count, BCD
//  BO     out  1          borrow-out, comb: 1 when Q==0 and state==RUN
//  zero   out  1          comb: 1 when Q==0
//  done   out  1          registered one-cycle pulse when count reaches 0
//  running out 1          1 when state==RUN
// BEHAVIOUR
//  Reset (CR=0, async): Q=0, state=IDLE, prescaler=0, done=0; holds while CR=0.
//  States: IDLE, RUN, PAUSED, DONE. Priority per edge: load > pause > start > tick.
//  load=1 (any state): Q<=P, digits >9 clamp to 9; prescaler<=0; state<=IDLE; done<=0.
//  IDLE: start=1 & Q!=0 -> RUN; start=1 & Q==0 -> stays IDLE (no done pulse).
//  RUN: prescaler counts 0..TICK_DIV-1; decrement on the edge where prescaler==TICK_DIV-1,
//   prescaler wraps to 0. pause=1 -> PAUSED, no decrement that edge, prescaler held.
//  PAUSED: Q and prescaler frozen; start=1 & pause=0 -> RUN (resumes mid-prescale).
//  start and pause both 1: pause wins (RUN->PAUSED, PAUSED stays).
//  Decrement: BCD borrow ripple; digit 0 -> 9 and borrow to next digit; digit n>0 -> n-1.
//  Decrement taking Q to 0: state<=DONE, done=1 for exactly the cycle following that edge.
//  DONE: Q holds 0, no wrap to 99..9; start/pause ignored; only load or CR leaves DONE.
//  Q never wraps below 0; Q never holds non-BCD digits.
//  Latency: load/start/pause take effect on the next CP edge; Q updates same edge as the tick.
//  CR deasserted mid-operation: all state lost, restarts from reset values.
// TESTING (DIGITS=2, TICK_DIV=3 unless noted)
//  1. CR=0 then release -> Q=8'h00, zero=1, running=0, done=0; start ignored (stays IDLE).
//  2. load P=8'h12, start -> Q 12,11,10,09,...,01,00 every 3 CP; done=1 one cycle at 00, state DONE.
//  3. Borrow: load 8'h10, TICK_DIV=1, start -> Q=09 after one CP, then 08; no 0F ever appears.
//  4. Pause 1 CP after a decrement, hold 5 CP, release with start -> next decrement exactly 2 CP later.
//  5. start=pause=1 in RUN -> PAUSED, Q frozen; load 8'h3A mid-RUN -> Q=39, IDLE, prescaler 0.
//  6. CR pulsed low mid-RUN at Q=05 -> Q=00 immediately (async), no done pulse, IDLE after release.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// Presettable BCD down-counter with run/pause control, tick prescaler and done pulse.
// Digits decrement through a per-digit borrow ripple; the final borrow-out doubles as the zero flag.

module bcd_digit_dec (
    input  logic [3:0] i_d,
    input  logic       i_bin,
    output logic [3:0] o_q,
    output logic       o_bout
);
    always_comb begin
        o_q    = i_d;
        o_bout = i_bin && (i_d == 4'd0);
        if (i_bin)
            o_q = (i_d == 4'd0) ? 4'd9 : i_d - 4'd1;
    end
endmodule

module bcd_countdown_timer #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 1
) (
    input  logic                  CP,
    input  logic                  CR,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   P,
    input  logic                  start,
    input  logic                  pause,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  BO,
    output logic                  zero,
    output logic                  done,
    output logic                  running
);
    localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

    state_t              r_state, w_state;
    logic [4*DIGITS-1:0] r_q, w_q;
    logic [PW-1:0]       r_pre, w_pre;
    logic                r_done, w_done;

    logic [DIGITS:0]     w_borrow;
    logic [4*DIGITS-1:0] w_dec;
    logic [4*DIGITS-1:0] w_clamp;

    // A borrow surviving past the top digit means every digit was already 0.
    assign w_borrow[0] = 1'b1;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            bcd_digit_dec u_dec (
                .i_d    (r_q[4*g +: 4]),
                .i_bin  (w_borrow[g]),
                .o_q    (w_dec[4*g +: 4]),
                .o_bout (w_borrow[g+1])
            );
            assign w_clamp[4*g +: 4] = (P[4*g +: 4] > 4'd9) ? 4'd9 : P[4*g +: 4];
        end
    endgenerate

    always_comb begin
        w_state = r_state;
        w_q     = r_q;
        w_pre   = r_pre;
        w_done  = 1'b0;
        if (load) begin
            w_q     = w_clamp;
            w_pre   = '0;
            w_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !pause && !w_borrow[DIGITS])
                        w_state = S_RUN;
                end
                S_RUN: begin
                    if (pause) begin
                        w_state = S_PAUSED;
                    end else if (r_pre == PRE_LAST) begin
                        w_pre = '0;
                        if (!w_borrow[DIGITS]) begin
                            w_q = w_dec;
                            if (w_dec == '0) begin
                                w_state = S_DONE;
                                w_done  = 1'b1;
                            end
                        end
                    end else begin
                        w_pre = r_pre + PW'(1);
                    end
                end
                S_PAUSED: begin
                    if (start && !pause)
                        w_state = S_RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_pre   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_q     <= w_q;
            r_pre   <= w_pre;
            r_done  <= w_done;
        end
    end

    assign Q       = r_q;
    assign zero    = w_borrow[DIGITS];
    assign running = (r_state == S_RUN);
    assign BO      = zero && running;
    assign done    = r_done;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: a 2-digit, 3-cycle-prescale instance plus a prescale-1 instance.
// Each step queues its expected {Q,done,running,zero,BO} and checks it after the next CP edge.

module tb_bcd_countdown_timer;
    logic       CP = 1'b0;
    logic       CR = 1'b0;
    logic       load = 1'b0;
    logic [7:0] P = 8'h00;
    logic       start = 1'b0;
    logic       pause = 1'b0;

    logic [7:0] Q,  Q1;
    logic       BO, zero, done, running;
    logic       BO1, zero1, done1, running1;

    int n_tot  = 0;
    int n_pass = 0;

    always #5 CP = ~CP;

    bcd_countdown_timer #(.DIGITS(2), .TICK_DIV(3)) u_dut (
        .CP(CP), .CR(CR), .load(load), .P(P), .start(start), .pause(pause),
        .Q(Q), .BO(BO), .zero(zero), .done(done), .running(running)
    );

    bcd_countdown_timer #(.DIGITS(2), .TICK_DIV(1)) u_dut1 (
        .CP(CP), .CR(CR), .load(load), .P(P), .start(start), .pause(pause),
        .Q(Q1), .BO(BO1), .zero(zero1), .done(done1), .running(running1)
    );

    typedef struct {
        logic       cr;
        logic       ld;
        logic [7:0] p;
        logic       st;
        logic       pa;
        logic [7:0] q;
        logic       dn;
        logic       run;
    } vec_t;

    typedef struct {
        string       nm;
        bit          sel;
        logic [11:0] exp;
    } sb_t;

    vec_t tbl[$];
    sb_t  sbq[$];

    function automatic logic [7:0] to_bcd(input int d);
        return {4'(d / 10), 4'(d % 10)};
    endfunction

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: {Q,done,run,zero,BO} got %h expected %h", nm, act, exp);
    endtask

    task automatic step(input logic ld, input logic [7:0] p, input logic st, input logic pa,
                        input bit sel, input logic [7:0] eq, input logic ed, input logic er,
                        input string nm);
        sb_t e;
        logic [11:0] act;
        load  = ld;
        P     = p;
        start = st;
        pause = pa;
        sbq.push_back('{nm, sel, {eq, ed, er, (eq == 8'h00), (eq == 8'h00) && er}});
        @(posedge CP);
        #1;
        e   = sbq.pop_front();
        act = e.sel ? {Q1, done1, running1, zero1, BO1} : {Q, done, running, zero, BO};
        chk(e.nm, act, e.exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        //            cr  ld  p      st  pa  q      dn  run
        tbl.push_back('{0, 0, 8'h00, 0, 0, 8'h00, 0, 0});  // held in reset
        tbl.push_back('{1, 0, 8'h00, 1, 0, 8'h00, 0, 0});  // start at zero ignored
        tbl.push_back('{1, 0, 8'h00, 0, 0, 8'h00, 0, 0});
        tbl.push_back('{1, 1, 8'h3A, 0, 0, 8'h39, 0, 0});  // low digit clamps to 9
        tbl.push_back('{1, 0, 8'h00, 1, 0, 8'h39, 0, 1});
        tbl.push_back('{1, 0, 8'h00, 0, 0, 8'h39, 0, 1});
        tbl.push_back('{1, 0, 8'h00, 1, 1, 8'h39, 0, 0});  // pause beats start
        tbl.push_back('{1, 0, 8'h00, 0, 0, 8'h39, 0, 0});
        tbl.push_back('{1, 0, 8'h00, 1, 0, 8'h39, 0, 1});  // resume mid-prescale
        tbl.push_back('{1, 0, 8'h00, 0, 0, 8'h39, 0, 1});
        tbl.push_back('{1, 0, 8'h00, 0, 0, 8'h38, 0, 1});
        tbl.push_back('{1, 0, 8'h00, 0, 0, 8'h38, 0, 1});
        tbl.push_back('{1, 1, 8'h3A, 0, 0, 8'h39, 0, 0});  // load mid-RUN
        tbl.push_back('{1, 0, 8'h00, 1, 0, 8'h39, 0, 1});
        tbl.push_back('{1, 0, 8'h00, 0, 0, 8'h39, 0, 1});
        tbl.push_back('{1, 0, 8'h00, 0, 0, 8'h39, 0, 1});
        tbl.push_back('{1, 0, 8'h00, 0, 0, 8'h38, 0, 1});  // prescaler restarted by load
        tbl.push_back('{1, 1, 8'hFF, 0, 0, 8'h99, 0, 0});
        tbl.push_back('{1, 1, 8'hA5, 1, 0, 8'h95, 0, 0});  // load beats start

        for (int i = 0; i < tbl.size(); i++) begin
            CR = tbl[i].cr;
            step(tbl[i].ld, tbl[i].p, tbl[i].st, tbl[i].pa, 1'b0,
                 tbl[i].q, tbl[i].dn, tbl[i].run, $sformatf("vec%0d", i));
        end

        // full countdown from 12 with a 3-cycle prescale
        step(1, 8'h12, 0, 0, 0, 8'h12, 0, 0, "cd_load");
        step(0, 8'h00, 1, 0, 0, 8'h12, 0, 1, "cd_start");
        for (int k = 1; k <= 36; k++)
            step(0, 8'h00, 0, 0, 0, to_bcd(12 - k / 3), (k == 36), (k < 36),
                 $sformatf("cd_k%0d", k));
        step(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, "cd_done_once");
        step(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, "cd_done_start");
        step(0, 8'h00, 1, 1, 0, 8'h00, 0, 0, "cd_done_pause");

        // pause one cycle after a decrement, resume two cycles before the next
        step(1, 8'h20, 0, 0, 0, 8'h20, 0, 0, "pz_load");
        step(0, 8'h00, 1, 0, 0, 8'h20, 0, 1, "pz_start");
        step(0, 8'h00, 0, 0, 0, 8'h20, 0, 1, "pz_p1");
        step(0, 8'h00, 0, 0, 0, 8'h20, 0, 1, "pz_p2");
        step(0, 8'h00, 0, 0, 0, 8'h19, 0, 1, "pz_dec");
        step(0, 8'h00, 0, 0, 0, 8'h19, 0, 1, "pz_after");
        for (int k = 0; k < 5; k++)
            step(0, 8'h00, 0, 1, 0, 8'h19, 0, 0, $sformatf("pz_hold%0d", k));
        step(0, 8'h00, 1, 0, 0, 8'h19, 0, 1, "pz_resume");
        step(0, 8'h00, 0, 0, 0, 8'h19, 0, 1, "pz_r1");
        step(0, 8'h00, 0, 0, 0, 8'h18, 0, 1, "pz_r2_dec");

        // borrow across digits with no prescale
        step(1, 8'h10, 0, 0, 1, 8'h10, 0, 0, "bw_load");
        step(0, 8'h00, 1, 0, 1, 8'h10, 0, 1, "bw_start");
        for (int k = 1; k <= 10; k++)
            step(0, 8'h00, 0, 0, 1, to_bcd(10 - k), (k == 10), (k < 10),
                 $sformatf("bw_k%0d", k));

        // async clear in the middle of a run
        step(1, 8'h08, 0, 0, 0, 8'h08, 0, 0, "cr_load");
        step(0, 8'h00, 1, 0, 0, 8'h08, 0, 1, "cr_start");
        for (int k = 1; k <= 9; k++)
            step(0, 8'h00, 0, 0, 0, to_bcd(8 - k / 3), 0, 1, $sformatf("cr_k%0d", k));
        #3;
        CR = 1'b0;
        #1;
        chk("cr_async", {Q, done, running, zero, BO}, {8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
        step(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, "cr_held");
        CR = 1'b1;
        step(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, "cr_release");
        step(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, "cr_idle_start");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
